// File: rtl/perm_pkg.sv
// Shared types and constants for the lane-permutation engine: lane/table sizes,
// the eight fixed permutation tables, the FSM state encoding and the LFSR step.
package perm_pkg;

  localparam int N_LANES = 16;
  localparam int N_PERMS = 8;

  typedef logic [3:0] perm_table_t [N_PERMS][N_LANES];

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Row r, entry i: source lane that becomes lane i after a round with table r.
  localparam perm_table_t PERM_TABLE = '{
    '{4'd10, 4'd7,  4'd12, 4'd6,  4'd11, 4'd4,  4'd13, 4'd3,
      4'd1,  4'd15, 4'd14, 4'd2,  4'd9,  4'd0,  4'd8,  4'd5},
    '{4'd8,  4'd9,  4'd3,  4'd1,  4'd13, 4'd12, 4'd5,  4'd14,
      4'd2,  4'd4,  4'd7,  4'd6,  4'd0,  4'd15, 4'd11, 4'd10},
    '{4'd15, 4'd14, 4'd13, 4'd12, 4'd11, 4'd10, 4'd9,  4'd8,
      4'd7,  4'd6,  4'd5,  4'd4,  4'd3,  4'd2,  4'd1,  4'd0},
    '{4'd1,  4'd2,  4'd3,  4'd4,  4'd5,  4'd6,  4'd7,  4'd8,
      4'd9,  4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15, 4'd0},
    '{4'd0,  4'd2,  4'd4,  4'd6,  4'd8,  4'd10, 4'd12, 4'd14,
      4'd1,  4'd3,  4'd5,  4'd7,  4'd9,  4'd11, 4'd13, 4'd15},
    '{4'd5,  4'd4,  4'd7,  4'd6,  4'd1,  4'd0,  4'd3,  4'd2,
      4'd13, 4'd12, 4'd15, 4'd14, 4'd9,  4'd8,  4'd11, 4'd10},
    '{4'd0,  4'd3,  4'd6,  4'd9,  4'd12, 4'd15, 4'd2,  4'd5,
      4'd8,  4'd11, 4'd14, 4'd1,  4'd4,  4'd7,  4'd10, 4'd13},
    '{4'd3,  4'd8,  4'd13, 4'd2,  4'd7,  4'd12, 4'd1,  4'd6,
      4'd11, 4'd0,  4'd5,  4'd10, 4'd15, 4'd4,  4'd9,  4'd14}
  };

  // Right-shifting Galois form of x^8+x^6+x^5+x^4+1.
  function automatic logic [7:0] lfsr_step(input logic [7:0] cur);
    lfsr_step = cur[0] ? ((cur >> 1) ^ 8'hB8) : (cur >> 1);
  endfunction

endpackage

// File: rtl/perm_apply.sv
// One permutation round: output lane i takes input lane PERM_TABLE[sel][i].
module perm_apply
  import perm_pkg::*;
#(
  parameter int LANE_W = 4
) (
  input  logic [2:0]                sel_i,
  input  logic [N_LANES*LANE_W-1:0] lanes_i,
  output logic [N_LANES*LANE_W-1:0] lanes_o
);

  always_comb begin
    lanes_o = '0;
    for (int i = 0; i < N_LANES; i++) begin
      lanes_o[i*LANE_W +: LANE_W] = lanes_i[PERM_TABLE[sel_i][i]*LANE_W +: LANE_W];
    end
  end

endmodule

// File: rtl/perm_round_engine.sv
// Iterative 16-lane permutation engine, one round per clock, valid/ready on both sides.
// Optional PERM_LFSR_SEL_EN: per-round table index taken from a free-running 8-bit LFSR.
module perm_round_engine
  import perm_pkg::*;
#(
  parameter int         LANE_W    = 4,
  parameter int         ROUNDS    = 4,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [16*LANE_W-1:0]  in_data,
  input  logic [2:0]            in_sel,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [16*LANE_W-1:0]  out_data,
  output logic                  busy
);

  localparam int DW = N_LANES * LANE_W;

  if (ROUNDS < 1 || ROUNDS > 255) begin : g_bad_rounds
    $error("perm_round_engine: ROUNDS must be in 1..255");
  end
  if (LFSR_SEED == 8'h00) begin : g_bad_seed
    $error("perm_round_engine: LFSR_SEED must be nonzero");
  end

  state_t         state_q, state_d;
  logic [DW-1:0]  data_q, data_d;
  logic [DW-1:0]  perm_data;
  logic [7:0]     cnt_q, cnt_d;
  logic [2:0]     sel_q, sel_d;
  logic [2:0]     round_sel;
  logic           last_round;

  assign last_round = (cnt_q == 8'(ROUNDS - 1));

`ifdef PERM_LFSR_SEL_EN
  logic [7:0] lfsr_q, lfsr_d;

  // The LFSR is never reloaded on accept, so its sequence runs on across blocks.
  assign lfsr_d    = (state_q == S_RUN) ? lfsr_step(lfsr_q) : lfsr_q;
  assign round_sel = lfsr_q[2:0] ^ sel_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`else
  assign round_sel = sel_q + cnt_q[2:0];
`endif

  perm_apply #(
    .LANE_W (LANE_W)
  ) u_perm_apply (
    .sel_i   (round_sel),
    .lanes_i (data_q),
    .lanes_o (perm_data)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          data_d  = in_data;
          sel_d   = in_sel;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        data_d = perm_data;
        cnt_d  = cnt_q + 8'd1;
        if (last_round) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // Return to IDLE only; the next accept happens a cycle later.
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_RUN);
  assign out_data  = data_q;

endmodule

// File: doc/perm_round_engine.md
# perm_round_engine

- Iterative multi-round lane-permutation engine.
- Accepts one block of 16 lanes of LANE_W bits over a valid/ready handshake.
- Applies ROUNDS permutation rounds, one round per clock; each round uses one of 8 fixed permutation tables.
- Presents the result on a valid/ready output; sits between the block source and the downstream consumer in the random-sequence datapath.

## Interface
- LANE_W, 4 — bits per lane; 1..32.
- ROUNDS, 4 — rounds per block; 1..255, 0 illegal (elaboration error).
- LFSR_SEED, 8'hA5 — LFSR reset value, nonzero; used only with PERM_LFSR_SEL_EN.
- clk  in  1  clock; single clock domain.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  input block valid.
- in_ready  out  1  engine can accept a block.
- in_data  in  16*LANE_W  lane i = in_data[i*LANE_W +: LANE_W].
- in_sel  in  3  starting table index; captured with the block.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  16*LANE_W  permuted block, same lane packing as in_data.
- busy  out  1  high while in RUN.

## Operation
- Round with table T: next lane i = current lane T[i].
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: load state register from in_data, capture in_sel, clear round counter, go to RUN.
- RUN:
  - in_ready=0, busy=1.
  - Each cycle: state <= perm(sel), counter+1.
  - On the cycle counter==ROUNDS-1, go to DONE.
- DONE:
  - out_valid=1; out_data = state register, held stable.
  - On out_ready: go to IDLE.
  - No new block is accepted in the same cycle as out_ready (no bypass).
- Handshake rules:
  - in_valid while not IDLE is ignored; in_data is not sampled.
  - out_valid does not drop until out_ready.
- Per-round table index sel (3 bits):
  - Without macro: sel = (captured in_sel + round counter) mod 8.
- Reset, asynchronous, any state including mid-RUN: FSM→IDLE, state register and counter→0, captured sel→0.
- Reset values of outputs: in_ready=1, out_valid=0, busy=0, out_data=0.
- A block in flight at reset is discarded, with no output.

## Timing
- Accept edge at cycle t; out_valid rises after edge t+ROUNDS.
- Earliest next accept: edge after the out_ready cycle.
- Minimum throughput: one block per ROUNDS+2 cycles.
- out_data is registered; no combinational path from in_* to out_*.
- in_ready and out_valid are decoded from FSM state only, not from in_valid or out_ready.

## Configuration
- PERM_LFSR_SEL_EN defined:
  - Adds an 8-bit Galois LFSR, polynomial x^8+x^6+x^5+x^4+1, reset to LFSR_SEED.
  - Advances one step per RUN cycle only.
  - Persists across blocks; it is not reloaded on accept.
  - Round index sel = lfsr[2:0] XOR captured in_sel.
- Undefined: LFSR absent; sel = counter-based rule above.

## Structure
- Package perm_pkg contains:
  - N_LANES=16, N_PERMS=8.
  - perm_table_t (8×16 array of 4-bit indices).
  - PERM_TABLE constant. Rows 0 and 1 are:
    - Table 0: 10,7,12,6,11,4,13,3,1,15,14,2,9,0,8,5.
    - Table 1: 8,9,3,1,13,12,5,14,2,4,7,6,0,15,11,10.
  - FSM state enum.
- Sub-module perm_apply: combinational, parameter LANE_W, inputs sel and lanes, output permuted lanes via PERM_TABLE. Instantiated once.

## Test plan
- ROUNDS=1, in_sel=0, lane i=i → out lanes 10,7,12,6,11,4,13,3,1,15,14,2,9,0,8,5; out_valid 1 cycle after accept.
- ROUNDS=2, in_sel=0, macro off, lane i=i → 1,15,6,7,0,9,4,8,12,11,3,13,10,5,2,14; out_valid exactly 2 cycles after accept.
- Backpressure: hold out_ready=0 for 10 cycles → out_valid and out_data stable, in_ready=0 throughout; a second in_valid pulse during this window is not accepted.
- Reset asserted mid-RUN, round 1 of 4 → in the same cycle in_ready=1, busy=0, out_valid=0; the next accepted block completes normally with a correct result.
- Back-to-back: in_valid held high, out_ready=1 → accepts spaced ROUNDS+2 cycles apart; every result is correct.
- PERM_LFSR_SEL_EN: two identical blocks in sequence → results match a reference model advancing the LFSR from 8'hA5 by ROUNDS steps per block; the second result differs from the first.
